sdram_rom_arbiter: RTL and testbench

Parametrised N-channel arbiter between ROM-reading clients and a single 32-bit SDRAM controller port. It is the successor to the fixed four-segment ROM mux. Adds a selectable fixed-priority or round-robin grant policy, a single-outstanding-read state machine with per-channel ack/valid routing, and a double-buffered IOCTL download packer with overflow detection. It sits between the per-ROM segment caches and the SDRAM controller.

---
 rtl/sdram_rom_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sdram_rom_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rom_arbiter.sv
// sdram_rom_arbiter: N-channel ROM read arbiter plus a double-buffered IOCTL
// download packer, sharing one 32-bit SDRAM controller port. Only one SDRAM
// transaction is ever outstanding; pending download words beat reads.
module sdram_rom_arbiter #(
  parameter int          NUM_CH      = 4,
  parameter int          ADDR_WIDTH  = 23,
  parameter int          DATA_WIDTH  = 32,
  parameter int          ROUND_ROBIN = 0,
  parameter logic [15:0] DL_INDEX    = 16'd0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_CH-1:0]            ch_req_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr_i,
  output logic [NUM_CH-1:0]            ch_ack_o,
  output logic [NUM_CH-1:0]            ch_valid_o,
  output logic [DATA_WIDTH-1:0]        ch_data_o,
  input  logic [24:0]                  ioctl_addr_i,
  input  logic [7:0]                   ioctl_data_i,
  input  logic [15:0]                  ioctl_index_i,
  input  logic                         ioctl_wr_i,
  input  logic                         ioctl_download_i,
  output logic                         dl_overflow_o,
  output logic [ADDR_WIDTH-1:0]        sdram_addr_o,
  output logic [DATA_WIDTH-1:0]        sdram_data_o,
  output logic                         sdram_we_o,
  output logic                         sdram_req_o,
  input  logic                         sdram_ack_i,
  input  logic                         sdram_valid_i,
  input  logic [DATA_WIDTH-1:0]        sdram_q_i
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                state_q;
  logic [CH_W-1:0]       grant_q, grant_d, rr_ptr_q, rr_idx;
  logic                  rr_found;
  logic [ADDR_WIDTH-1:0] sdram_addr_q;
  logic [DATA_WIDTH-1:0] sdram_data_q, ch_data_q;
  logic                  sdram_we_q, sdram_req_q;
  logic [NUM_CH-1:0]     ch_valid_q;

  // Two staging words: fill_sel_q is being packed, wr_sel_q is the oldest full one.
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [ADDR_WIDTH-1:0] buf_addr_q [2];
  logic [1:0]            buf_full_q;
  logic                  fill_sel_q, wr_sel_q, dl_prev_q, dl_overflow_q;

  logic                  dl_accept, dl_rise, dl_fall, wr_release, read_ack;
  logic [LANE_W-1:0]     dl_lane;
  logic [ADDR_WIDTH-1:0] dl_word_addr;
  logic [ADDR_WIDTH-1:0] ch_addr_arr [NUM_CH];

  assign dl_accept    = ioctl_download_i && ioctl_wr_i && (ioctl_index_i == DL_INDEX);
  assign dl_rise      = ioctl_download_i && !dl_prev_q;
  assign dl_fall      = !ioctl_download_i && dl_prev_q;
  assign dl_lane      = ioctl_addr_i[LANE_W-1:0];
  assign dl_word_addr = ADDR_WIDTH'(ioctl_addr_i >> LANE_W);
  assign wr_release   = (state_q == S_ISSUE) && sdram_ack_i && sdram_we_q;
  assign read_ack     = (state_q == S_ISSUE) && sdram_ack_i && !sdram_we_q;

  // Unflatten channel addresses and route the accept pulse to the granted channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_addr_arr[gi] = ch_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign ch_ack_o[gi]    = read_ack && (grant_q == CH_W'(gi));
  end

  assign ch_valid_o    = ch_valid_q;
  assign ch_data_o     = ch_data_q;
  assign dl_overflow_o = dl_overflow_q;
  assign sdram_addr_o  = sdram_addr_q;
  assign sdram_data_o  = sdram_data_q;
  assign sdram_we_o    = sdram_we_q;
  assign sdram_req_o   = sdram_req_q;

  // Grant selection: lowest index in fixed mode, first at/after the pointer in RR mode.
  always_comb begin
    grant_d  = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    if (ROUND_ROBIN != 0) begin
      for (int k = 0; k < NUM_CH; k++) begin
        rr_idx = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
        if (!rr_found && ch_req_i[rr_idx]) begin
          grant_d  = rr_idx;
          rr_found = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (ch_req_i[CH_W'(k)]) grant_d = CH_W'(k);
      end
    end
  end

  // Download packer: little-endian byte lanes, alternate words, sticky overflow.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_addr_q[0] <= '0;
      buf_addr_q[1] <= '0;
      buf_full_q    <= '0;
      fill_sel_q    <= 1'b0;
      wr_sel_q      <= 1'b0;
      dl_prev_q     <= 1'b0;
      dl_overflow_q <= 1'b0;
    end else begin
      dl_prev_q <= ioctl_download_i;
      if (wr_release) begin
        buf_full_q[wr_sel_q] <= 1'b0;
        wr_sel_q             <= ~wr_sel_q;
      end
      if (dl_rise) dl_overflow_q <= 1'b0;
      // A partly packed word at download end is thrown away.
      if (dl_fall && !buf_full_q[fill_sel_q]) buf_data_q[fill_sel_q] <= '0;
      if (dl_accept) begin
        if (buf_full_q[fill_sel_q]) begin
          dl_overflow_q <= 1'b1;
        end else begin
          for (int b = 0; b < BYTES; b++) begin
            if (dl_lane == LANE_W'(b)) buf_data_q[fill_sel_q][b*8 +: 8] <= ioctl_data_i;
          end
          if (&dl_lane) begin
            buf_full_q[fill_sel_q] <= 1'b1;
            buf_addr_q[fill_sel_q] <= dl_word_addr;
            fill_sel_q             <= ~fill_sel_q;
          end
        end
      end
    end
  end

  // Transaction FSM: IDLE picks a write or a read, ISSUE holds the request, WAIT returns data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      sdram_addr_q <= '0;
      sdram_data_q <= '0;
      sdram_we_q   <= 1'b0;
      sdram_req_q  <= 1'b0;
      ch_valid_q   <= '0;
      ch_data_q    <= '0;
    end else begin
      ch_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (buf_full_q[wr_sel_q]) begin
            sdram_addr_q <= buf_addr_q[wr_sel_q];
            sdram_data_q <= buf_data_q[wr_sel_q];
            sdram_we_q   <= 1'b1;
            sdram_req_q  <= 1'b1;
            state_q      <= S_ISSUE;
          end else if (!ioctl_download_i && (|ch_req_i)) begin
            grant_q      <= grant_d;
            sdram_addr_q <= ch_addr_arr[grant_d];
            sdram_we_q   <= 1'b0;
            sdram_req_q  <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sdram_ack_i) begin
            sdram_req_q <= 1'b0;
            if (sdram_we_q) begin
              state_q <= S_IDLE;
            end else begin
              rr_ptr_q <= (int'(grant_q) == NUM_CH - 1) ? '0 : grant_q + 1'b1;
              state_q  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (sdram_valid_i) begin
            ch_data_q           <= sdram_q_i;
            ch_valid_q[grant_q] <= 1'b1;
            state_q             <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Bench for sdram_rom_arbiter: a fixed-priority and a round-robin instance
// share stimulus; rr_sel picks which instance's outputs are checked.
module tb_sdram_rom_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 23;
  localparam int DW  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  ch_req;
  logic [NCH*AW-1:0] ch_addr;
  logic [24:0]     ioctl_addr;
  logic [7:0]      ioctl_data;
  logic [15:0]     ioctl_index;
  logic            ioctl_wr, ioctl_download;
  logic            sdram_ack, sdram_valid;
  logic [DW-1:0]   sdram_q;

  logic [NCH-1:0]  ack_f, valid_f, ack_r, valid_r;
  logic [DW-1:0]   data_f, data_r, sdata_f, sdata_r;
  logic [AW-1:0]   saddr_f, saddr_r;
  logic            ovf_f, ovf_r, we_f, we_r, req_f, req_r;

  bit              rr_sel = 1'b0;
  logic [NCH-1:0]  t_ack, t_valid;
  logic [DW-1:0]   t_data, t_sdata;
  logic [AW-1:0]   t_saddr;
  logic            t_ovf, t_we, t_req;

  assign t_ack   = rr_sel ? ack_r   : ack_f;
  assign t_valid = rr_sel ? valid_r : valid_f;
  assign t_data  = rr_sel ? data_r  : data_f;
  assign t_sdata = rr_sel ? sdata_r : sdata_f;
  assign t_saddr = rr_sel ? saddr_r : saddr_f;
  assign t_ovf   = rr_sel ? ovf_r   : ovf_f;
  assign t_we    = rr_sel ? we_r    : we_f;
  assign t_req   = rr_sel ? req_r   : req_f;

  always #5 clk = ~clk;

  sdram_rom_arbiter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0), .DL_INDEX(16'd0)) u_fix (
    .clk_i(clk), .reset_i(reset), .ch_req_i(ch_req), .ch_addr_i(ch_addr),
    .ch_ack_o(ack_f), .ch_valid_o(valid_f), .ch_data_o(data_f),
    .ioctl_addr_i(ioctl_addr), .ioctl_data_i(ioctl_data), .ioctl_index_i(ioctl_index),
    .ioctl_wr_i(ioctl_wr), .ioctl_download_i(ioctl_download), .dl_overflow_o(ovf_f),
    .sdram_addr_o(saddr_f), .sdram_data_o(sdata_f), .sdram_we_o(we_f), .sdram_req_o(req_f),
    .sdram_ack_i(sdram_ack), .sdram_valid_i(sdram_valid), .sdram_q_i(sdram_q));

  sdram_rom_arbiter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1), .DL_INDEX(16'd0)) u_rr (
    .clk_i(clk), .reset_i(reset), .ch_req_i(ch_req), .ch_addr_i(ch_addr),
    .ch_ack_o(ack_r), .ch_valid_o(valid_r), .ch_data_o(data_r),
    .ioctl_addr_i(ioctl_addr), .ioctl_data_i(ioctl_data), .ioctl_index_i(ioctl_index),
    .ioctl_wr_i(ioctl_wr), .ioctl_download_i(ioctl_download), .dl_overflow_o(ovf_r),
    .sdram_addr_o(saddr_r), .sdram_data_o(sdata_r), .sdram_we_o(we_r), .sdram_req_o(req_r),
    .sdram_ack_i(sdram_ack), .sdram_valid_i(sdram_valid), .sdram_q_i(sdram_q));

  typedef struct {
    bit          rr;
    bit          do_rst;
    logic [3:0]  req;
    logic [3:0]  exp_ack;
    logic [31:0] q;
  } vec_t;

  vec_t vecs [14];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [AW-1:0] ch_base(input int i);
    return AW'(32'h012340 + 32'h010101 * i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (t_req !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check(name, 64'(t_req), 64'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    ch_req = '0; ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_index = '0;
    sdram_ack = 1'b0; sdram_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_sdram_req", 64'(t_req), 64'd0);
    check("rst_sdram_we", 64'(t_we), 64'd0);
    check("rst_sdram_addr", 64'(t_saddr), 64'd0);
    check("rst_ch_valid", 64'(t_valid), 64'd0);
    check("rst_ch_data", 64'(t_data), 64'd0);
    check("rst_dl_overflow", 64'(t_ovf), 64'd0);
  endtask

  task automatic run_read(input int vi, input logic [3:0] exp_ack, input logic [31:0] q,
                          input logic [3:0] next_req);
    int ch = 0;
    for (int i = 0; i < NCH; i++) if (exp_ack[i]) ch = i;
    wait_req("rd_req");
    check("rd_we", 64'(t_we), 64'd0);
    check("rd_addr", 64'(t_saddr), 64'(ch_base(ch)));
    sdram_ack = 1'b1;
    #1;
    check("rd_ch_ack", 64'(t_ack), 64'(exp_ack));
    tick();
    sdram_ack = 1'b0;
    check("rd_req_drop", 64'(t_req), 64'd0);
    tick();
    tick();
    sdram_q = q;
    sdram_valid = 1'b1;
    tick();
    sdram_valid = 1'b0;
    ch_req = next_req;
    check("rd_ch_valid", 64'(t_valid), 64'(exp_ack));
    check("rd_ch_data", 64'(t_data), 64'(q));
    tick();
    check("rd_valid_once", 64'(t_valid), 64'd0);
    $display("read  vec %0d: rr=%0d ch%0d data 0x%08h", vi, rr_sel, ch, q);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
    wait_req("wr_req");
    check("wr_we", 64'(t_we), 64'd1);
    check("wr_addr", 64'(t_saddr), 64'(a));
    check("wr_data", 64'(t_sdata), 64'(d));
    sdram_ack = 1'b1;
    #1;
    check("wr_no_ch_ack", 64'(t_ack), 64'd0);
    tick();
    sdram_ack = 1'b0;
    check("wr_req_drop", 64'(t_req), 64'd0);
    $display("write addr 0x%0h data 0x%08h", a, d);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic [15:0] idx);
    ioctl_addr  = a;
    ioctl_data  = d;
    ioctl_index = idx;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [3:0] nreq;
    reset = 1'b1;
    ch_req = '0; ioctl_addr = '0; ioctl_data = '0; ioctl_index = '0;
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_q = '0;
    for (int i = 0; i < NCH; i++) ch_addr[i*AW +: AW] = ch_base(i);

    // Fixed priority: ch1 wins over ch3 until it drops its request.
    vecs[0]  = '{1'b0, 1'b1, 4'b1010, 4'b0010, 32'hA000_0001};
    vecs[1]  = '{1'b0, 1'b0, 4'b1010, 4'b0010, 32'hA000_0002};
    vecs[2]  = '{1'b0, 1'b0, 4'b1000, 4'b1000, 32'hA000_0003};
    vecs[3]  = '{1'b0, 1'b0, 4'b0110, 4'b0010, 32'hA000_0004};
    vecs[4]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 32'hA000_0005};
    vecs[5]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 32'hA000_0006};
    // Round robin: rotation with all requesting, then pointer-relative picks.
    vecs[6]  = '{1'b1, 1'b1, 4'b1111, 4'b0001, 32'hB000_0000};
    vecs[7]  = '{1'b1, 1'b0, 4'b1111, 4'b0010, 32'hB000_0011};
    vecs[8]  = '{1'b1, 1'b0, 4'b1111, 4'b0100, 32'hB000_0022};
    vecs[9]  = '{1'b1, 1'b0, 4'b1111, 4'b1000, 32'hB000_0033};
    vecs[10] = '{1'b1, 1'b0, 4'b1111, 4'b0001, 32'hB000_0044};
    vecs[11] = '{1'b1, 1'b0, 4'b1010, 4'b0010, 32'hB000_0055};
    vecs[12] = '{1'b1, 1'b0, 4'b1001, 4'b1000, 32'hB000_0066};
    vecs[13] = '{1'b1, 1'b0, 4'b0110, 4'b0010, 32'hB000_0077};

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_rst) begin
        rr_sel = vecs[i].rr;
        apply_reset();
        ch_req = vecs[i].req;
      end
      nreq = 4'b0;
      if (i < 13) begin
        if (!vecs[i+1].do_rst) nreq = vecs[i+1].req;
      end
      run_read(i, vecs[i].exp_ack, vecs[i].q, nreq);
    end

    // Single packed word, then a partial word that must never be written.
    rr_sel = 1'b0;
    apply_reset();
    ioctl_download = 1'b1;
    send_byte(25'h000100, 8'h11, 16'd0);
    send_byte(25'h000101, 8'h22, 16'd0);
    send_byte(25'h000102, 8'h33, 16'd0);
    send_byte(25'h000103, 8'h44, 16'd0);
    do_write(23'h40, 32'h4433_2211);
    send_byte(25'h000104, 8'h55, 16'd0);
    send_byte(25'h000105, 8'h66, 16'd0);
    ioctl_download = 1'b0;
    repeat (5) tick();
    check("partial_word_dropped", 64'(t_req), 64'd0);

    // Stalled SDRAM: two words buffer, remaining bytes overflow.
    apply_reset();
    ioctl_download = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_byte(25'(32'h200 + i), 8'(i + 1), 16'd0);
      if (i == 7) check("ovf_before_third_word", 64'(t_ovf), 64'd0);
      if (i == 8) check("ovf_set", 64'(t_ovf), 64'd1);
    end
    ioctl_download = 1'b0;
    do_write(23'h80, 32'h0403_0201);
    do_write(23'h81, 32'h0807_0605);
    repeat (5) tick();
    check("ovf_no_third_write", 64'(t_req), 64'd0);
    check("ovf_sticky", 64'(t_ovf), 64'd1);
    ioctl_download = 1'b1;
    tick();
    tick();
    check("ovf_clear_on_rise", 64'(t_ovf), 64'd0);
    ioctl_download = 1'b0;
    tick();

    // Download starts while a ch2 read waits for data; index-1 bytes are ignored.
    apply_reset();
    ch_req = 4'b0100;
    wait_req("c_rd_req");
    check("c_rd_addr", 64'(t_saddr), 64'(ch_base(2)));
    sdram_ack = 1'b1;
    #1;
    check("c_ch_ack", 64'(t_ack), 64'b0100);
    tick();
    sdram_ack = 1'b0;
    ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(25'(32'h20 + i), 8'(32'h90 + i), 16'd1);
    for (int i = 0; i < 4; i++) send_byte(25'(32'h10 + i), 8'(32'hAA + 32'h11 * i), 16'd0);
    check("c_no_req_during_wait", 64'(t_req), 64'd0);
    sdram_q = 32'h5A5A_0001;
    sdram_valid = 1'b1;
    tick();
    sdram_valid = 1'b0;
    ch_req = 4'b0000;
    check("c_ch_valid", 64'(t_valid), 64'b0100);
    check("c_ch_data", 64'(t_data), 64'h5A5A_0001);
    do_write(23'h4, 32'hDDCC_BBAA);
    repeat (5) tick();
    check("c_index1_ignored", 64'(t_req), 64'd0);
    ioctl_download = 1'b0;

    // Reset in ISSUE: request drops at once, a late valid is ignored.
    apply_reset();
    ch_req = 4'b0001;
    wait_req("d_req");
    reset = 1'b1;
    #1;
    check("d_req_async_clear", 64'(t_req), 64'd0);
    tick();
    reset = 1'b0;
    ch_req = 4'b0000;
    sdram_q = 32'hDEAD_BEEF;
    sdram_valid = 1'b1;
    tick();
    sdram_valid = 1'b0;
    check("d_late_valid_ignored", 64'(t_valid), 64'd0);
    check("d_late_data_ignored", 64'(t_data), 64'd0);
    tick();
    check("d_idle_no_req", 64'(t_req), 64'd0);
    ch_req = 4'b0010;
    tick();
    check("d_one_cycle_latency", 64'(t_req), 64'd1);
    check("d_addr_after_reset", 64'(t_saddr), 64'(ch_base(1)));
    $display("reset-in-issue sequence done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
